bcd_4_digit: RTL and testbench

BCD_4_DIGIT -- requirements
Module: bcd_4_digit

---
 rtl/bcd_4_digit_pkg.sv | 21 ++
 rtl/bcd_add3.sv | 16 +
 rtl/bcd_4_digit.sv | 102 ++++++++++
 tb/tb_bcd_4_digit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/bcd_4_digit_pkg.sv
// -----------------------------------------------------------------------------
// bcd_4_digit_pkg
// Shared definitions for the 4-digit binary-to-BCD converter.
//   state_t    : converter FSM states (LOAD, SHIFT, DONE)
//   MAX_VAL    : largest value representable in four BCD digits
//   BLANK_CODE : nibble driven on overflow when BCD_OVERFLOW_BLANK_EN is defined
//   SAT_CODE   : nibble driven on overflow otherwise (all digits read 9)
// -----------------------------------------------------------------------------
package bcd_4_digit_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int unsigned MAX_VAL    = 9999;
   localparam logic [3:0]  BLANK_CODE = 4'hF;
   localparam logic [3:0]  SAT_CODE   = 4'd9;

endpackage

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Double-dabble nibble correction: adds 3 when the nibble is 5 or more, so the
// following left shift carries correctly into the next decimal digit.
// Ports:
//   i_nib : input  4  BCD nibble before correction
//   o_nib : output 4  corrected nibble
// -----------------------------------------------------------------------------
module bcd_add3 (
   input  logic [3:0] i_nib,
   output logic [3:0] o_nib
);

   assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/bcd_4_digit.sv
// -----------------------------------------------------------------------------
// bcd_4_digit
// Free-running sequential binary-to-BCD converter (shift-add-3). Each period
// is LOAD (1 cycle) -> SHIFT (VALUE_W cycles) -> DONE (1 cycle), i.e.
// VALUE_W+2 cycles. The four digit outputs are registered and all update
// together in DONE, holding steady for the rest of the period.
// Values above 9999 saturate to 9999, or, when the macro
// BCD_OVERFLOW_BLANK_EN is defined, drive the blank code 4'hF on every digit.
// Parameters:
//   VALUE_W : binary input width, 11..14 (default 14)
// Ports:
//   clk   : input  1        clock, rising edge
//   rst   : input  1        asynchronous active-high reset
//   value : input  VALUE_W  unsigned binary value to convert
//   A     : output 4        thousands digit
//   B     : output 4        hundreds digit
//   C     : output 4        tens digit
//   D     : output 4        units digit
// -----------------------------------------------------------------------------
module bcd_4_digit
   import bcd_4_digit_pkg::*;
#(
   parameter int VALUE_W = 14
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [VALUE_W-1:0] value,
   output logic [3:0]         A,
   output logic [3:0]         B,
   output logic [3:0]         C,
   output logic [3:0]         D
);

   localparam int CNT_W = $clog2(VALUE_W);

`ifdef BCD_OVERFLOW_BLANK_EN
   localparam logic [3:0] OVF_NIB = BLANK_CODE;
`else
   localparam logic [3:0] OVF_NIB = SAT_CODE;
`endif

   state_t             r_state;
   logic [VALUE_W-1:0] r_bin;
   logic [15:0]        r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ovf;
   logic [15:0]        r_dig;
   logic [15:0]        w_corr;

   // Correct every nibble of the accumulator before the shift.
   for (genvar g = 0; g < 4; g++) begin : g_add3
      bcd_add3 u_add3 (
         .i_nib (r_acc[4*g +: 4]),
         .o_nib (w_corr[4*g +: 4])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= LOAD;
         r_bin   <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
         r_dig   <= '0;
      end else begin
         case (r_state)
            LOAD: begin
               // The sampled copy isolates the conversion from later input changes.
               r_bin   <= value;
               r_acc   <= '0;
               r_ovf   <= (32'(value) > MAX_VAL);
               r_cnt   <= '0;
               r_state <= SHIFT;
            end
            SHIFT: begin
               r_acc <= {w_corr[14:0], r_bin[VALUE_W-1]};
               r_bin <= r_bin << 1;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(VALUE_W - 1)) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               // Thousands nibble may be corrupt for values above 9999; the
               // overflow flag overrides it.
               r_dig   <= r_ovf ? {4{OVF_NIB}} : r_acc;
               r_state <= LOAD;
            end
            default: begin
               r_state <= LOAD;
            end
         endcase
      end
   end

   assign A = r_dig[15:12];
   assign B = r_dig[11:8];
   assign C = r_dig[7:4];
   assign D = r_dig[3:0];

endmodule

// File: tb/tb_bcd_4_digit.sv
// -----------------------------------------------------------------------------
// tb_bcd_4_digit
// Directed self-checking bench for bcd_4_digit (VALUE_W = 14). Expected digits
// come from decimal arithmetic on the applied value. Define
// BCD_OVERFLOW_BLANK_EN to expect blank-coded overflow results.
// -----------------------------------------------------------------------------
module tb_bcd_4_digit;

   logic        clk;
   logic        rst;
   logic [13:0] value;
   logic [3:0]  A, B, C, D;

   int tests;
   int fails;

   logic [15:0] prev_dig;

`ifdef BCD_OVERFLOW_BLANK_EN
   localparam logic [15:0] OVF_EXP = 16'hFFFF;
`else
   localparam logic [15:0] OVF_EXP = 16'h9999;
`endif

   bcd_4_digit #(.VALUE_W(14)) dut (
      .clk   (clk),
      .rst   (rst),
      .value (value),
      .A     (A),
      .B     (B),
      .C     (C),
      .D     (D)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] ref_bcd(input int v);
      logic [15:0] r;
      if (v > 9999) begin
         r = OVF_EXP;
      end else begin
         r[15:12] = 4'(v / 1000);
         r[11:8]  = 4'((v / 100) % 10);
         r[7:4]   = 4'((v / 10) % 10);
         r[3:0]   = 4'(v % 10);
      end
      return r;
   endfunction

   // Entered at a negedge just before a LOAD edge; returns at the negedge
   // after DONE, which is again just before the next LOAD edge.
   task automatic convert(input int v, input string nm);
      logic [15:0] exp_dig;
      logic        unstable;
      logic [15:0] got;
      exp_dig  = ref_bcd(v);
      unstable = 1'b0;
      got      = '0;
      value    = 14'(v);
      repeat (15) begin
         @(posedge clk);
         #1;
         if ({A, B, C, D} !== prev_dig) begin
            unstable = 1'b1;
            got      = {A, B, C, D};
         end
      end
      tests++;
      if (unstable) begin
         fails++;
         $display("FAIL %s_stable: outputs %h before DONE, held value should be %h", nm, got, prev_dig);
      end
      @(posedge clk);
      #1;
      tests++;
      if ({A, B, C, D} !== exp_dig) begin
         fails++;
         $display("FAIL %s (value=%0d): got %h expected %h", nm, v, {A, B, C, D}, exp_dig);
      end
      prev_dig = exp_dig;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      value    = 14'd6031;
      prev_dig = 16'h0000;
      #50;
      tests++;
      if ({A, B, C, D} !== 16'h0000) begin
         fails++;
         $display("FAIL reset_outputs: got %h expected 0000", {A, B, C, D});
      end
      #50;
      rst = 1'b0;
   endtask

   task automatic test_first_conversion();
      convert(6031, "first_6031");
   endtask

   task automatic test_limits();
      convert(0, "zero");
      convert(9999, "max9999");
      convert(1, "one");
      convert(1000, "thousand");
      convert(9090, "pattern9090");
   endtask

   task automatic test_overflow();
      convert(10000, "ovf10000");
      convert(16383, "ovf16383");
      convert(9998, "below_ovf");
      convert(12345, "ovf12345");
   endtask

   task automatic test_value_change();
      logic [15:0] got;
      value = 14'd1234;
      repeat (6) @(posedge clk);
      @(negedge clk);
      value = 14'd5678;
      repeat (10) @(posedge clk);
      #1;
      got = {A, B, C, D};
      tests++;
      if (got !== 16'h1234) begin
         fails++;
         $display("FAIL change_first: got %h expected 1234", got);
      end
      prev_dig = 16'h1234;
      @(negedge clk);
      convert(5678, "change_second");
   endtask

   task automatic test_reset_mid_shift();
      logic [15:0] got;
      value = 14'd4321;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      got = {A, B, C, D};
      tests++;
      if (got !== 16'h0000) begin
         fails++;
         $display("FAIL async_reset: got %h expected 0000", got);
      end
      repeat (3) @(negedge clk);
      rst      = 1'b0;
      prev_dig = 16'h0000;
      convert(4321, "after_reset");
   endtask

   task automatic test_sweep();
      for (int v = 3; v <= 9999; v += 7) begin
         convert(v, "sweep");
      end
      convert(9997, "sweep_end");
   endtask

   initial begin
      tests = 0;
      fails = 0;
      value = '0;
      rst   = 1'b1;
      test_reset();
      test_first_conversion();
      test_limits();
      test_overflow();
      test_value_change();
      test_reset_mid_shift();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
